shift_pipe: RTL and testbench

SHIFT_PIPE -- requirements
Module: shift_pipe

---
 rtl/shift_pipe.sv | 117 +++++++++++
 tb/tb_shift_pipe.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/shift_pipe.sv
// rtl/shift_pipe.sv - two-stage shift/rotate pipeline with valid/ready handshakes
module shift_pipe (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  input  logic [4:0]  in_shamt,
  input  logic [1:0]  in_op,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        out_zero,
  output logic        out_lost,
  output logic        busy
);

  typedef enum logic [1:0] {
    OP_SLL = 2'b00,
    OP_SRL = 2'b01,
    OP_SRA = 2'b10,
    OP_ROL = 2'b11
  } op_t;

  logic        s1_valid;
  logic [31:0] s1_data;
  logic [4:0]  s1_shamt;
  op_t         s1_op;

  logic        s2_valid;
  logic [31:0] s2_data;
  logic        s2_zero;
  logic        s2_lost;

  logic        s1_load;
  logic        s2_load;
  logic [31:0] shift_res;
  logic        shift_lost;

  assign s2_load  = s1_valid && (!s2_valid || out_ready);
  assign in_ready = !s1_valid || s2_load;
  assign s1_load  = in_valid && in_ready;

  // Masks select the bits that leave the word; a zero shift gives an empty mask.
  always_comb begin
    logic [31:0] ones;
    ones       = '1;
    shift_res  = s1_data;
    shift_lost = 1'b0;
    case (s1_op)
      OP_SLL: begin
        shift_res  = s1_data << s1_shamt;
        shift_lost = |(s1_data & ~(ones >> s1_shamt));
      end
      OP_SRL: begin
        shift_res  = s1_data >> s1_shamt;
        shift_lost = |(s1_data & ~(ones << s1_shamt));
      end
      OP_SRA: begin
        shift_res  = $signed(s1_data) >>> s1_shamt;
        shift_lost = |(s1_data & ~(ones << s1_shamt));
      end
      OP_ROL: begin
        shift_res  = (s1_data << s1_shamt) | (s1_data >> (6'd32 - {1'b0, s1_shamt}));
        shift_lost = 1'b0;
      end
      default: begin
        shift_res  = s1_data;
        shift_lost = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
      s1_shamt <= '0;
      s1_op    <= OP_SLL;
    end else begin
      if (s1_load) begin
        s1_valid <= 1'b1;
        s1_data  <= in_data;
        s1_shamt <= in_shamt;
        s1_op    <= op_t'(in_op);
      end else if (s2_load) begin
        s1_valid <= 1'b0;
      end
    end
  end

  // S2 contents only change on a load, so a stalled result stays stable.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      s2_valid <= 1'b0;
      s2_data  <= '0;
      s2_zero  <= 1'b0;
      s2_lost  <= 1'b0;
    end else begin
      if (s2_load) begin
        s2_valid <= 1'b1;
        s2_data  <= shift_res;
        s2_zero  <= (shift_res == 32'd0);
        s2_lost  <= shift_lost;
      end else if (out_ready) begin
        s2_valid <= 1'b0;
      end
    end
  end

  assign out_valid = s2_valid;
  assign out_data  = s2_data;
  assign out_zero  = s2_zero;
  assign out_lost  = s2_lost;
  assign busy      = s1_valid || s2_valid;

endmodule

// File: tb/tb_shift_pipe.sv
// tb/tb_shift_pipe.sv - randomized and directed bench for shift_pipe against a queue model
module tb_shift_pipe;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = '0;
  logic [4:0]  in_shamt = '0;
  logic [1:0]  in_op = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic        out_zero;
  logic        out_lost;
  logic        busy;

  int vectors = 0;
  int miscompares = 0;

  shift_pipe dut (
    .clock(clock), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_shamt(in_shamt), .in_op(in_op),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_zero(out_zero), .out_lost(out_lost),
    .busy(busy)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: shift one bit at a time and note every 1 that falls off the word.
  function automatic logic [33:0] ref_shift(input logic [1:0] op, input logic [31:0] d,
                                            input logic [4:0] sh);
    logic [31:0] r;
    logic        lost;
    r = d;
    lost = 1'b0;
    for (int i = 0; i < int'(sh); i++) begin
      case (op)
        2'b00: begin lost = lost | r[31]; r = {r[30:0], 1'b0}; end
        2'b01: begin lost = lost | r[0];  r = {1'b0, r[31:1]}; end
        2'b10: begin lost = lost | r[0];  r = {r[31], r[31:1]}; end
        default: r = {r[30:0], r[31]};
      endcase
    end
    return {lost, (r == 32'd0), r};
  endfunction

  // Model: queue of results in acceptance order; a lone entry accepted at the
  // latest edge is still in flight and not yet visible.
  logic [33:0] q[$];
  bit          fresh = 1'b0;

  function automatic bit exp_out_valid();
    return (q.size() >= 2) || (q.size() == 1 && !fresh);
  endfunction

  function automatic bit exp_in_ready();
    return (q.size() < 2) || out_ready;
  endfunction

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      q.delete();
      fresh <= 1'b0;
    end else begin
      bit pop, push;
      pop  = exp_out_valid() && out_ready;
      push = in_valid && exp_in_ready();
      if (pop) void'(q.pop_front());
      if (push) q.push_back(ref_shift(in_op, in_data, in_shamt));
      fresh <= push;
    end
  end

  always @(negedge clock) begin
    if (!reset_n) begin
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
      chk("rst_out_data", out_data, 32'd0);
      chk("rst_flags", {30'd0, out_zero, out_lost}, 32'd0);
    end else begin
      chk("out_valid", {31'd0, out_valid}, {31'd0, exp_out_valid()});
      chk("in_ready", {31'd0, in_ready}, {31'd0, exp_in_ready()});
      chk("busy", {31'd0, busy}, {31'd0, q.size() > 0});
      if (exp_out_valid()) begin
        chk("out_data", out_data, q[0][31:0]);
        chk("out_zero", {31'd0, out_zero}, {31'd0, q[0][32]});
        chk("out_lost", {31'd0, out_lost}, {31'd0, q[0][33]});
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Single request into an empty pipe, with literal expectations.
  task automatic directed(input string name, input logic [1:0] op, input logic [31:0] d,
                          input logic [4:0] sh, input logic [31:0] ed, input bit ez, input bit el);
    out_ready = 1'b1;
    in_valid = 1'b1; in_op = op; in_data = d; in_shamt = sh;
    chk({name, "_ready"}, {31'd0, in_ready}, 32'd1);
    step();
    in_valid = 1'b0;
    chk({name, "_lat1"}, {31'd0, out_valid}, 32'd0);
    step();
    chk({name, "_lat2"}, {31'd0, out_valid}, 32'd1);
    chk({name, "_data"}, out_data, ed);
    chk({name, "_flags"}, {30'd0, out_zero, out_lost}, {30'd0, ez, el});
    step();
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    while ((q.size() > 0 || busy) && n < 20) begin
      step();
      n++;
    end
    chk({name, "_drained"}, {31'd0, (q.size() == 0) && !busy}, 32'd1);
  endtask

  initial begin
    int accepts, seen, run;
    logic [31:0] held;

    #12;
    reset_n = 1'b1;
    step();

    directed("sll31", 2'b00, 32'h00000001, 5'd31, 32'h80000000, 1'b0, 1'b0);
    directed("sll1",  2'b00, 32'h80000001, 5'd1,  32'h00000002, 1'b0, 1'b1);
    directed("rol1",  2'b11, 32'h80000001, 5'd1,  32'h00000003, 1'b0, 1'b0);
    directed("sra4",  2'b10, 32'h80000000, 5'd4,  32'hF8000000, 1'b0, 1'b0);
    directed("srl5",  2'b01, 32'h000000F0, 5'd5,  32'h00000007, 1'b0, 1'b1);
    directed("srl1z", 2'b01, 32'h00000001, 5'd1,  32'h00000000, 1'b1, 1'b1);
    directed("sra0",  2'b10, 32'h8000F00F, 5'd0,  32'h8000F00F, 1'b0, 1'b0);
    directed("rol31", 2'b11, 32'h00000003, 5'd31, 32'h80000001, 1'b0, 1'b0);

    // Streaming: 8 back-to-back requests, results on consecutive cycles.
    out_ready = 1'b1;
    seen = 0; run = 0;
    for (int i = 0; i < 12; i++) begin
      in_valid = (i < 8);
      in_op = 2'(i); in_data = 32'h1 << i; in_shamt = 5'(i);
      if (i < 8) chk("stream_in_ready", {31'd0, in_ready}, 32'd1);
      step();
      if (out_valid) begin seen++; run++; end
      else if (seen > 0 && seen < 8) run = 0;
    end
    chk("stream_count", 32'(seen), 32'd8);
    chk("stream_consecutive", 32'(run), 32'd8);
    drain("stream");

    // Backpressure: 5 cycles with out_ready low.
    out_ready = 1'b0;
    accepts = 0;
    held = '0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_op = 2'b01; in_data = 32'hA5A5_0000 + 32'(i); in_shamt = 5'(i + 1);
      if (in_ready) accepts++;
      step();
      if (i == 2) held = out_data;
      if (i > 2) chk("bp_hold", out_data, held);
    end
    chk("bp_accepts", 32'(accepts), 32'd2);
    chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
    drain("bp");

    // Reset with two entries in flight.
    out_ready = 1'b0;
    in_valid = 1'b1; in_op = 2'b00; in_data = 32'hFFFF_FFFF; in_shamt = 5'd3;
    step(); step();
    in_valid = 1'b0;
    chk("pre_rst_busy", {31'd0, busy}, 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_out_valid", {31'd0, out_valid}, 32'd0);
    chk("async_busy", {31'd0, busy}, 32'd0);
    chk("async_in_ready", {31'd0, in_ready}, 32'd1);
    step();
    reset_n = 1'b1;
    directed("post_rst", 2'b01, 32'h0000_0100, 5'd8, 32'h00000001, 1'b0, 1'b0);
    chk("post_rst_empty", {31'd0, busy}, 32'd0);

    // Randomized traffic with corner-biased shift amounts and data.
    for (int i = 0; i < 600; i++) begin
      int sel;
      in_valid = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      in_op = 2'($urandom_range(0, 3));
      sel = $urandom_range(0, 7);
      in_shamt = (sel == 0) ? 5'd0 : (sel == 1) ? 5'd31 : 5'($urandom_range(0, 31));
      sel = $urandom_range(0, 7);
      in_data = (sel == 0) ? 32'd0 : (sel == 1) ? 32'hFFFF_FFFF : (sel == 2) ? 32'h8000_0000 : $urandom;
      step();
    end
    drain("random");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
